// File: rtl/mx_int8_vector.sv
// Holds one MX block of MXINT8 elements, refilled from a 32-bit LFSR one element per cycle.
// A single element can be zeroed in IDLE, or deferred to the final fill edge while a fill runs.
module mx_int8_vector #(
    parameter int          BLOCK_SIZE = 32,
    parameter int          ELEM_WIDTH = 8,
    parameter logic [31:0] SEED       = 32'hACE1_2B5D,
    parameter int          ALLOW_MIN  = 0
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               rand_start_i,
    input  logic                               set_zero_i,
    input  logic [$clog2(BLOCK_SIZE)-1:0]      zero_idx_i,
    output logic [BLOCK_SIZE*ELEM_WIDTH-1:0]   elements_o,
    output logic                               busy_o,
    output logic                               valid_o,
    output logic                               done_o
);

    localparam int          IW       = $clog2(BLOCK_SIZE);
    localparam logic [31:0] SEED_EFF = (SEED == 32'd0) ? 32'd1 : SEED;

    typedef enum logic {IDLE, FILL} state_t;

    state_t                state, state_nxt;
    logic [31:0]           lfsr, lfsr_nxt;
    logic [IW-1:0]         idx, pend_idx, zero_sel;
    logic                  pend_vld, zero_ok, last, zero_wr;
    logic [ELEM_WIDTH-1:0] rand_byte;
    logic [ELEM_WIDTH-1:0] mem [BLOCK_SIZE];

    // Eight Fibonacci steps unrolled into a single combinational stage.
    function automatic logic [31:0] lfsr_step8(input logic [31:0] s);
        logic [31:0] t;
        t = s;
        for (int k = 0; k < 8; k++) begin
            t = {t[30:0], t[31] ^ t[21] ^ t[1] ^ t[0]};
        end
        return t;
    endfunction

    always_comb begin
        lfsr_nxt  = lfsr_step8(lfsr);
        rand_byte = lfsr_nxt[ELEM_WIDTH-1:0];
        if (ALLOW_MIN == 0 && rand_byte == {1'b1, {(ELEM_WIDTH-1){1'b0}}}) begin
            rand_byte = {1'b1, {(ELEM_WIDTH-2){1'b0}}, 1'b1};
        end
    end

    assign zero_ok  = set_zero_i && ({1'b0, zero_idx_i} < (IW+1)'(BLOCK_SIZE));
    assign last     = (idx == IW'(BLOCK_SIZE - 1));
    // A request arriving on the final fill edge is newer than any pending one.
    assign zero_sel = zero_ok ? zero_idx_i : pend_idx;
    assign zero_wr  = ((state == IDLE) && !rand_start_i && zero_ok) ||
                      ((state == FILL) && last && (zero_ok || pend_vld));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (rand_start_i) state_nxt = FILL;
            FILL:    if (last)         state_nxt = IDLE;
            default:                   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy_o = (state == FILL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr     <= SEED_EFF;
            idx      <= '0;
            pend_vld <= 1'b0;
            pend_idx <= '0;
            valid_o  <= 1'b0;
            done_o   <= 1'b0;
            for (int i = 0; i < BLOCK_SIZE; i++) begin
                mem[i] <= '0;
            end
        end else begin
            done_o <= 1'b0;
            if (state == IDLE) begin
                if (rand_start_i) begin
                    idx      <= '0;
                    valid_o  <= 1'b0;
                    pend_vld <= zero_ok;
                    pend_idx <= zero_idx_i;
                end else if (zero_ok) begin
                    done_o <= 1'b1;
                end
            end else begin
                lfsr <= lfsr_nxt;
                idx  <= idx + 1'b1;
                if (zero_ok) begin
                    pend_vld <= 1'b1;
                    pend_idx <= zero_idx_i;
                end
                if (last) begin
                    pend_vld <= 1'b0;
                    valid_o  <= 1'b1;
                    done_o   <= 1'b1;
                end
            end
            // Zero write is ordered after the random write so it wins on an index match.
            for (int i = 0; i < BLOCK_SIZE; i++) begin
                if (state == FILL && idx == IW'(i)) mem[i] <= rand_byte;
                if (zero_wr && zero_sel == IW'(i))  mem[i] <= '0;
            end
        end
    end

    for (genvar g = 0; g < BLOCK_SIZE; g++) begin : g_out
        assign elements_o[(BLOCK_SIZE-1-g)*ELEM_WIDTH +: ELEM_WIDTH] = mem[g];
    end

endmodule

// File: tb/tb_mx_int8_vector.sv
// Directed bench for mx_int8_vector: two instances (ALLOW_MIN 0 and 1) share stimulus.
module tb_mx_int8_vector;
    localparam int          BS   = 32;
    localparam int          W    = BS * 8;
    localparam logic [31:0] SEED = 32'hACE1_2B5D;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         rand_start = 1'b0;
    logic         set_zero = 1'b0;
    logic [4:0]   zero_idx = '0;
    logic [W-1:0] el0, el1;
    logic         busy0, valid0, done0, busy1, valid1, done1;

    int           checks = 0;
    int           failures = 0;
    logic [31:0]  m;
    logic [W-1:0] exp0, exp1, first_blk;
    int           cnt80_0 = 0, cnt80_1 = 0, cnt80_m = 0;

    typedef struct {
        bit         zero;
        logic [4:0] idx;
        bit         exp_done;
    } zvec_t;

    always #5 clk = ~clk;

    mx_int8_vector #(.BLOCK_SIZE(BS), .ELEM_WIDTH(8), .SEED(SEED), .ALLOW_MIN(0)) dut0 (
        .clk(clk), .rst(rst), .rand_start_i(rand_start), .set_zero_i(set_zero),
        .zero_idx_i(zero_idx), .elements_o(el0), .busy_o(busy0), .valid_o(valid0), .done_o(done0));

    mx_int8_vector #(.BLOCK_SIZE(BS), .ELEM_WIDTH(8), .SEED(SEED), .ALLOW_MIN(1)) dut1 (
        .clk(clk), .rst(rst), .rand_start_i(rand_start), .set_zero_i(set_zero),
        .zero_idx_i(zero_idx), .elements_o(el1), .busy_o(busy1), .valid_o(valid1), .done_o(done1));

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic logic [7:0] get_byte(input logic [W-1:0] v, input int i);
        return v[(BS-1-i)*8 +: 8];
    endfunction

    // Reference: advance the model LFSR one bit at a time, 8 bits per element.
    task automatic model_fill();
        logic [7:0] b;
        for (int i = 0; i < BS; i++) begin
            for (int k = 0; k < 8; k++) m = {m[30:0], m[31] ^ m[21] ^ m[1] ^ m[0]};
            b = m[7:0];
            if (b == 8'h80) cnt80_m++;
            exp1[(BS-1-i)*8 +: 8] = b;
            exp0[(BS-1-i)*8 +: 8] = (b == 8'h80) ? 8'h81 : b;
        end
    endtask

    task automatic do_fill(input int za, input int ia, input int zb, input int ib,
                           input int rs_at, input string tag);
        int         c, busycnt;
        bit         pv;
        logic [4:0] pend;
        logic [4:0] ia5, ib5;
        ia5 = ia[4:0];
        ib5 = ib[4:0];
        pv = (za == 0);
        pend = ia5;
        @(negedge clk);
        rand_start = 1'b1;
        set_zero = (za == 0);
        zero_idx = ia5;
        @(negedge clk);
        rand_start = 1'b0;
        set_zero = 1'b0;
        c = 1;
        busycnt = 0;
        while (!done0 && c < BS + 8) begin
            if (busy0) busycnt++;
            rand_start = (c == rs_at);
            set_zero = (c == za) || (c == zb);
            zero_idx = (c == zb) ? ib5 : ia5;
            if (c == za) begin pv = 1'b1; pend = ia5; end
            if (c == zb) begin pv = 1'b1; pend = ib5; end
            @(negedge clk);
            rand_start = 1'b0;
            set_zero = 1'b0;
            c++;
        end
        check({tag, " fill_latency"}, W'(c - 1), W'(BS));
        check({tag, " busy_cycles"}, W'(busycnt), W'(BS));
        check({tag, " done_pulse"}, {done1, done0}, 2'b11);
        check({tag, " busy_valid_end"}, {busy0, valid0, busy1, valid1}, 4'b0101);
        model_fill();
        if (pv) begin
            exp0[(BS-1-pend)*8 +: 8] = 8'h00;
            exp1[(BS-1-pend)*8 +: 8] = 8'h00;
        end
        check({tag, " elems_min0"}, el0, exp0);
        check({tag, " elems_min1"}, el1, exp1);
        for (int i = 0; i < BS; i++) begin
            if (get_byte(el0, i) == 8'h80) cnt80_0++;
            if (get_byte(el1, i) == 8'h80) cnt80_1++;
        end
        @(negedge clk);
        check({tag, " done_one_cycle"}, {done1, done0}, 2'b00);
    endtask

    initial begin
        zvec_t tbl[4];
        tbl[0] = '{1'b1, 5'd5,  1'b1};
        tbl[1] = '{1'b1, 5'd0,  1'b1};
        tbl[2] = '{1'b0, 5'd9,  1'b0};
        tbl[3] = '{1'b1, 5'd31, 1'b1};

        #12;
        check("reset_elems", el0, '0);
        check("reset_flags", {busy0, valid0, done0}, 3'b000);
        @(negedge clk);
        rst = 1'b0;
        m = SEED;

        // First fill; a stray start at fill cycle 5 must be ignored.
        do_fill(-1, 0, -1, 0, 5, "fill1");
        check("fill1 elem0_const", W'(get_byte(el0, 0)), W'(8'h8D));
        first_blk = el0;

        foreach (tbl[t]) begin
            @(negedge clk);
            set_zero = tbl[t].zero;
            zero_idx = tbl[t].idx;
            @(negedge clk);
            set_zero = 1'b0;
            check($sformatf("idle_zero%0d done", t), W'(done0), W'(tbl[t].exp_done));
            check($sformatf("idle_zero%0d valid", t), W'(valid0), W'(1'b1));
            if (tbl[t].zero) begin
                exp0[(BS-1-tbl[t].idx)*8 +: 8] = 8'h00;
                exp1[(BS-1-tbl[t].idx)*8 +: 8] = 8'h00;
            end
            check($sformatf("idle_zero%0d elems", t), el0, exp0);
            check($sformatf("idle_zero%0d elems1", t), el1, exp1);
        end

        // Pending zero: idx 31 at cycle 10, replaced by idx 3 at cycle 20.
        do_fill(10, 31, 20, 3, -1, "zfill");
        check("zfill elem3", W'(get_byte(el0, 3)), W'(8'h00));
        check("zfill elem31", W'(get_byte(el0, 31)), W'(get_byte(exp0, 31)));

        // Zero request together with the start request in IDLE.
        do_fill(0, 7, -1, 0, -1, "startzero");
        for (int f = 0; f < 60; f++) do_fill(-1, 0, -1, 0, -1, $sformatf("b2b%0d", f));
        check("no_0x80_when_min0", W'(cnt80_0), W'(0));
        check("0x80_count_min1", W'(cnt80_1), W'(cnt80_m));
        check("0x80_seen_min1", W'(cnt80_1 > 0), W'(1));

        // Asynchronous reset at fill cycle 15.
        @(negedge clk);
        rand_start = 1'b1;
        @(negedge clk);
        rand_start = 1'b0;
        repeat (14) @(negedge clk);
        check("pre_reset_busy", W'(busy0), W'(1'b1));
        #2 rst = 1'b1;
        #1;
        check("async_reset_elems", el0, '0);
        check("async_reset_flags", {busy0, valid0, done0, busy1}, 4'b0000);
        @(negedge clk);
        rst = 1'b0;
        m = SEED;
        do_fill(-1, 0, -1, 0, -1, "after_rst");
        check("after_rst same_as_first", el0, first_blk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mx_int8_vector.md
Name: mx_int8_vector

Overview:
Stimulus-source block that holds one MX block of MXINT8 elements and refills it with pseudo-random two's-complement bytes on request. It can also force a single selected element to zero. It feeds MXINT8 datapath units (negate, etc.) in verification and BIST configurations. Output is a packed vector with element 0 in the most-significant slot.

Parameters:
BLOCK_SIZE, 32, number of elements per MX block (2..64)
ELEM_WIDTH, 8, bits per MXINT8 element (fixed 8 for MXINT8)
SEED, 32'hACE1_2B5D, LFSR reset value; 0 is replaced by 1
ALLOW_MIN, 0, 1 = 0x80 may be emitted; 0 = generated 0x80 is replaced by 0x81 (symmetric range)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
rand_start_i  in  1  single-cycle request to regenerate the whole block
set_zero_i  in  1  single-cycle request to zero one element
zero_idx_i  in  clog2(BLOCK_SIZE)  element index to zero, sampled with set_zero_i
elements_o  out  BLOCK_SIZE*ELEM_WIDTH  element i at bits [(BLOCK_SIZE-1-i)*8 +: 8]
busy_o  out  1  fill in progress
valid_o  out  1  block holds a completed random fill
done_o  out  1  one-cycle pulse when the block contents are final after a fill or zero write

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high on rst.
- Reset values:
  - elements_o = 0; busy_o, valid_o, done_o = 0.
  - LFSR = SEED (or 1 if SEED = 0); state IDLE; no pending zero.
- LFSR:
  - 32-bit Fibonacci; per step fb = s[31]^s[21]^s[1]^s[0], s <= {s[30:0], fb}.
  - Advances exactly 8 steps per fill cycle, unrolled combinationally, and holds otherwise.
- States: IDLE, FILL.
- IDLE + rand_start_i:
  - Next edge: FILL, idx = 0, busy_o = 1, valid_o = 0.
- FILL, each cycle:
  - LFSR advances 8 steps; element[idx] <= new s[7:0].
  - If ALLOW_MIN = 0, a value of 0x80 is written as 0x81.
  - idx increments.
- Fill completion:
  - The cycle that writes idx = BLOCK_SIZE-1 returns to IDLE.
  - busy_o = 0, valid_o = 1, done_o pulses for one cycle.
  - Fill latency: BLOCK_SIZE cycles from the first edge after the request.
- rand_start_i while in FILL is ignored.
- set_zero_i in IDLE without rand_start_i:
  - Next edge: element[zero_idx_i] <= 0 and done_o pulses.
  - valid_o is unchanged; LFSR does not advance.
- set_zero_i during FILL, or simultaneous with rand_start_i in IDLE:
  - Index is latched as a pending zero.
  - Applied on the final fill edge; the zero write overrides that cycle's random write if the indices match.
  - A later set_zero_i during the same fill overwrites the pending index (last one wins).
- zero_idx_i >= BLOCK_SIZE: request ignored, no done_o pulse.
- Element slots not being written hold their value.
- Reset mid-FILL aborts to the reset state. The sequence after reset is bit-identical to the sequence after power-up.
- The 8-step LFSR update must synthesize as one combinational stage with no multicycle path.

Test Plan:
- Reset check: assert rst asynchronously mid-cycle -> elements_o = 0, busy_o = valid_o = done_o = 0 immediately.
- Single fill: rand_start_i at cycle 0 ->
  - busy_o high cycles 1..32, done_o pulse at cycle 32, valid_o = 1 after.
  - Each element equals the reference-model LFSR byte; element 0 = low byte of SEED advanced 8 steps.
- Ten back-to-back fills (start on each done_o) -> every block matches the model; no element ever equals 0x80 with ALLOW_MIN = 0; repeat with ALLOW_MIN = 1 and confirm 0x80 can appear.
- Zero in IDLE: after a fill, set_zero_i with zero_idx_i = 5 -> element 5 = 0x00, other 31 elements unchanged, done_o pulses, valid_o stays 1.
- Zero during fill: set_zero_i with zero_idx_i = 31 at fill cycle 10, then zero_idx_i = 3 at cycle 20 -> after done_o, element 3 = 0x00 and element 31 = model value.
- Reset at fill cycle 15, then new start -> busy_o clears immediately on reset; the second fill reproduces the first post-reset block exactly.
